// File: rtl/gauss_window_loader.sv
// rtl/gauss_window_loader.sv - 3x3 window sequencer feeding the Gaussian tap bank
//
// Purpose:
//   Walks a 3x3 window over an 8-bit row-major image in data RAM. For each
//   window it reads the nine taps and writes them into the Gaussian bank at
//   tap addresses 1..9. It then waits FILTER_LAT cycles and stores the
//   filtered pixel into the output buffer. Border pixels produce no output.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   start_i        1-cycle pulse, begins a frame when idle
//   busy_o         high while a frame is in progress
//   done_o         1-cycle pulse at end of frame
//   rd_en_o        RAM read strobe
//   rd_addr_o      RAM read address
//   rd_data_i      RAM read data, valid the cycle after rd_en_o
//   gauss_we_o     bank write enable
//   gauss_addr_o   bank tap address 1..9
//   gauss_pixel_o  bank write data
//   gauss_result_i filtered pixel from the filter
//   wr_en_o        RAM write strobe for the result
//   wr_addr_o      RAM write address
//   wr_data_o      RAM write data
module gauss_window_loader #(
  parameter int IMG_W      = 16,
  parameter int IMG_H      = 16,
  parameter int ADDR_W     = 16,
  parameter int IN_BASE    = 0,
  parameter int OUT_BASE   = 256,
  parameter int FILTER_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [7:0]        rd_data_i,
  output logic              gauss_we_o,
  output logic [3:0]        gauss_addr_o,
  output logic [7:0]        gauss_pixel_o,
  input  logic [7:0]        gauss_result_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o
);

  localparam int MAX_DIM = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam int CW      = $clog2(MAX_DIM) + 1;
  localparam int WW      = $clog2(FILTER_LAT + 2);
  localparam bit DEGEN   = (IMG_W < 3) || (IMG_H < 3);

  localparam logic [CW-1:0]     ONE_C      = CW'(1);
  localparam logic [CW-1:0]     C_LAST     = CW'(IMG_W - 2);
  localparam logic [CW-1:0]     R_LAST     = CW'(IMG_H - 2);
  localparam logic [ADDR_W-1:0] ZERO_A     = '0;
  localparam logic [ADDR_W-1:0] ONE_A      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO_A      = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] IMG_W_A    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] OUT_W_A    = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] IN_BASE_A  = ADDR_W'(IN_BASE);
  localparam logic [ADDR_W-1:0] OUT_BASE_A = ADDR_W'(OUT_BASE);
  localparam logic [WW-1:0]     LAT_W      = WW'(FILTER_LAT);
  localparam logic [WW-1:0]     ONE_W      = WW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_PWAIT,
    S_STORE,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic [3:0]    k_q, k_d;
  logic [WW-1:0] wcnt_q, wcnt_d;

  logic              busy_q;
  logic              done_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              gauss_we_q;
  logic [3:0]        gauss_addr_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;

  // Tap k (1..9) sits at row offset (k-1)/3 and column offset (k-1)%3
  // relative to the window's top-left pixel (r-1, c-1).
  function automatic logic [ADDR_W-1:0] rd_addr_f(input logic [CW-1:0] r,
                                                  input logic [CW-1:0] c,
                                                  input logic [3:0]    k);
    logic [ADDR_W-1:0] dr;
    logic [ADDR_W-1:0] dc;
    dr = ZERO_A;
    dc = ZERO_A;
    case (k)
      4'd2:    begin dr = ZERO_A; dc = ONE_A; end
      4'd3:    begin dr = ZERO_A; dc = TWO_A; end
      4'd4:    begin dr = ONE_A;  dc = ZERO_A; end
      4'd5:    begin dr = ONE_A;  dc = ONE_A; end
      4'd6:    begin dr = ONE_A;  dc = TWO_A; end
      4'd7:    begin dr = TWO_A;  dc = ZERO_A; end
      4'd8:    begin dr = TWO_A;  dc = ONE_A; end
      4'd9:    begin dr = TWO_A;  dc = TWO_A; end
      default: begin dr = ZERO_A; dc = ZERO_A; end
    endcase
    rd_addr_f = IN_BASE_A + (ADDR_W'(r) - ONE_A + dr) * IMG_W_A
              + (ADDR_W'(c) - ONE_A + dc);
  endfunction

  function automatic logic [ADDR_W-1:0] wr_addr_f(input logic [CW-1:0] r,
                                                  input logic [CW-1:0] c);
    wr_addr_f = OUT_BASE_A + (ADDR_W'(r) - ONE_A) * OUT_W_A + (ADDR_W'(c) - ONE_A);
  endfunction

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    k_d     = k_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (DEGEN) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD;
            r_d     = ONE_C;
            c_d     = ONE_C;
            k_d     = 4'd1;
          end
        end
      end
      S_RD: state_d = S_WR;
      S_WR: begin
        if (k_q != 4'd9) begin
          k_d     = k_q + 4'd1;
          state_d = S_RD;
        end else if (FILTER_LAT == 0) begin
          state_d = S_STORE;
        end else begin
          wcnt_d  = LAT_W;
          state_d = S_PWAIT;
        end
      end
      S_PWAIT: begin
        // PWAIT lasts exactly FILTER_LAT cycles.
        wcnt_d = wcnt_q - ONE_W;
        if (wcnt_q <= ONE_W) begin
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        if ((r_q == R_LAST) && (c_q == C_LAST)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RD;
          k_d     = 4'd1;
          if (c_q < C_LAST) begin
            c_d = c_q + ONE_C;
          end else begin
            c_d = ONE_C;
            r_d = r_q + ONE_C;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes and addresses are registered decodes of the next state, so they
  // line up with state_q in the following cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      r_q          <= '0;
      c_q          <= '0;
      k_q          <= '0;
      wcnt_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      gauss_we_q   <= 1'b0;
      gauss_addr_q <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      c_q          <= c_d;
      k_q          <= k_d;
      wcnt_q       <= wcnt_d;
      busy_q       <= (state_d == S_RD) || (state_d == S_WR) ||
                      (state_d == S_PWAIT) || (state_d == S_STORE);
      done_q       <= (state_d == S_DONE);
      rd_en_q      <= (state_d == S_RD);
      rd_addr_q    <= (state_d == S_RD) ? rd_addr_f(r_d, c_d, k_d) : ZERO_A;
      gauss_we_q   <= (state_d == S_WR);
      gauss_addr_q <= (state_d == S_WR) ? k_d : 4'd0;
      wr_en_q      <= (state_d == S_STORE);
      wr_addr_q    <= (state_d == S_STORE) ? wr_addr_f(r_d, c_d) : ZERO_A;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign rd_en_o       = rd_en_q;
  assign rd_addr_o     = rd_addr_q;
  assign gauss_we_o    = gauss_we_q;
  assign gauss_addr_o  = gauss_addr_q;
  // RAM data only arrives in the WR cycle, so the pixel is passed through
  // under the registered strobe rather than registered itself.
  assign gauss_pixel_o = gauss_we_q ? rd_data_i : 8'h00;
  assign wr_en_o       = wr_en_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_data_o     = wr_en_q ? gauss_result_i : 8'h00;

endmodule

// File: tb/tb_gauss_window_loader.sv
// tb/tb_gauss_window_loader.sv - scoreboard bench for gauss_window_loader
module tb_gauss_window_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // dut_a: 3x3, RAM[i]=i+1, result 8'h5A
  logic start_a = 1'b0;
  logic busy_a, done_a, rd_en_a, gauss_we_a, wr_en_a;
  logic [15:0] rd_addr_a, wr_addr_a;
  logic [7:0]  rd_data_a = 8'h00;
  logic [3:0]  gauss_addr_a;
  logic [7:0]  gauss_pixel_a, gauss_result_a, wr_data_a;
  assign gauss_result_a = 8'h5A;

  // dut_b: 4x4, RAM[i]=i, result = sum of taps >> 4
  logic start_b = 1'b0;
  logic busy_b, done_b, rd_en_b, gauss_we_b, wr_en_b;
  logic [15:0] rd_addr_b, wr_addr_b;
  logic [7:0]  rd_data_b = 8'h00;
  logic [3:0]  gauss_addr_b;
  logic [7:0]  gauss_pixel_b, gauss_result_b, wr_data_b;
  logic [7:0]  tap_b [0:15];

  // dut_f: 3x3, FILTER_LAT=0, RAM[i]=i+1, result 8'hC3
  logic start_f = 1'b0;
  logic busy_f, done_f, rd_en_f, gauss_we_f, wr_en_f;
  logic [15:0] rd_addr_f, wr_addr_f;
  logic [7:0]  rd_data_f = 8'h00;
  logic [3:0]  gauss_addr_f;
  logic [7:0]  gauss_pixel_f, gauss_result_f, wr_data_f;
  assign gauss_result_f = 8'hC3;

  // dut_w: IMG_W=2, degenerate
  logic start_w = 1'b0;
  logic busy_w, done_w, rd_en_w, gauss_we_w, wr_en_w;
  logic [15:0] rd_addr_w, wr_addr_w;
  logic [7:0]  rd_data_w, gauss_result_w;
  logic [3:0]  gauss_addr_w;
  logic [7:0]  gauss_pixel_w, wr_data_w;
  assign rd_data_w      = 8'h00;
  assign gauss_result_w = 8'h00;

  gauss_window_loader #(.IMG_W(3), .IMG_H(3)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
    .rd_en_o(rd_en_a), .rd_addr_o(rd_addr_a), .rd_data_i(rd_data_a),
    .gauss_we_o(gauss_we_a), .gauss_addr_o(gauss_addr_a), .gauss_pixel_o(gauss_pixel_a),
    .gauss_result_i(gauss_result_a), .wr_en_o(wr_en_a), .wr_addr_o(wr_addr_a),
    .wr_data_o(wr_data_a));

  gauss_window_loader #(.IMG_W(4), .IMG_H(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
    .rd_en_o(rd_en_b), .rd_addr_o(rd_addr_b), .rd_data_i(rd_data_b),
    .gauss_we_o(gauss_we_b), .gauss_addr_o(gauss_addr_b), .gauss_pixel_o(gauss_pixel_b),
    .gauss_result_i(gauss_result_b), .wr_en_o(wr_en_b), .wr_addr_o(wr_addr_b),
    .wr_data_o(wr_data_b));

  gauss_window_loader #(.IMG_W(3), .IMG_H(3), .FILTER_LAT(0)) dut_f (
    .clk_i(clk), .rst_i(rst), .start_i(start_f), .busy_o(busy_f), .done_o(done_f),
    .rd_en_o(rd_en_f), .rd_addr_o(rd_addr_f), .rd_data_i(rd_data_f),
    .gauss_we_o(gauss_we_f), .gauss_addr_o(gauss_addr_f), .gauss_pixel_o(gauss_pixel_f),
    .gauss_result_i(gauss_result_f), .wr_en_o(wr_en_f), .wr_addr_o(wr_addr_f),
    .wr_data_o(wr_data_f));

  gauss_window_loader #(.IMG_W(2)) dut_w (
    .clk_i(clk), .rst_i(rst), .start_i(start_w), .busy_o(busy_w), .done_o(done_w),
    .rd_en_o(rd_en_w), .rd_addr_o(rd_addr_w), .rd_data_i(rd_data_w),
    .gauss_we_o(gauss_we_w), .gauss_addr_o(gauss_addr_w), .gauss_pixel_o(gauss_pixel_w),
    .gauss_result_i(gauss_result_w), .wr_en_o(wr_en_w), .wr_addr_o(wr_addr_w),
    .wr_data_o(wr_data_w));

  // Synchronous RAM models: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    rd_data_a <= rd_en_a ? 8'(rd_addr_a + 16'd1) : 8'h00;
    rd_data_b <= rd_en_b ? 8'(rd_addr_b) : 8'h00;
    rd_data_f <= rd_en_f ? 8'(rd_addr_f + 16'd1) : 8'h00;
    if (gauss_we_b) tap_b[gauss_addr_b] <= gauss_pixel_b;
  end

  always_comb begin
    int s;
    s = 0;
    for (int i = 1; i <= 9; i++) s += int'(tap_b[i]);
    gauss_result_b = 8'(s >> 4);
  end

  task automatic test_reset();
    int pairs = 0;
    int bad_wr = 0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy_a, done_a, rd_en_a, rd_addr_a, gauss_we_a, gauss_addr_a, gauss_pixel_a,
         wr_en_a, wr_addr_a, wr_data_a} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs_a: got busy=%b rd_en=%b we=%b wr_en=%b, expected all 0",
               busy_a, rd_en_a, gauss_we_a, wr_en_a);
    end
    rst = 1'b0;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    for (int cyc = 0; cyc < 40 && pairs < 5; cyc++) begin
      if (gauss_we_b) pairs++;
      if (pairs < 5) @(negedge clk);
    end
    tests_run++;
    if (pairs !== 5) begin
      tests_failed++;
      $display("FAIL reset_prefix_pairs: got %0d, expected 5", pairs);
    end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({busy_b, done_b, rd_en_b, rd_addr_b, gauss_we_b, gauss_addr_b, gauss_pixel_b,
         wr_en_b, wr_addr_b, wr_data_b} !== '0) begin
      tests_failed++;
      $display("FAIL reset_midframe_outputs: got busy=%b rd_en=%b addr=%0d we=%b gaddr=%0d, expected all 0",
               busy_b, rd_en_b, rd_addr_b, gauss_we_b, gauss_addr_b);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (wr_en_b || busy_b || rd_en_b) bad_wr++;
    end
    tests_run++;
    if (bad_wr !== 0) begin
      tests_failed++;
      $display("FAIL reset_no_activity_after: got %0d active cycles, expected 0", bad_wr);
    end
  endtask

  task automatic test_frame_3x3();
    int exp_rd[$];
    int exp_ga[$];
    int exp_gp[$];
    int exp_wa[$];
    int exp_wd[$];
    int e;
    int first_rd = -1;
    int done_cyc = -1;
    int overlap = 0;
    for (int k = 1; k <= 9; k++) begin
      exp_rd.push_back(k - 1);
      exp_ga.push_back(k);
      exp_gp.push_back(k);
    end
    exp_wa.push_back(256);
    exp_wd.push_back(8'h5A);
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (32'(rd_en_a) + 32'(gauss_we_a) + 32'(wr_en_a) > 1) overlap++;
      if (rd_en_a) begin
        if (first_rd < 0) first_rd = cyc;
        e = (exp_rd.size() != 0) ? exp_rd.pop_front() : -1;
        tests_run++;
        if (rd_addr_a !== 16'(e)) begin
          tests_failed++;
          $display("FAIL rd_addr_3x3: got %0d, expected %0d", rd_addr_a, e);
        end
      end
      if (gauss_we_a) begin
        e = (exp_ga.size() != 0) ? exp_ga.pop_front() : -1;
        tests_run++;
        if (gauss_addr_a !== 4'(e)) begin
          tests_failed++;
          $display("FAIL gauss_addr_3x3: got %0d, expected %0d", gauss_addr_a, e);
        end
        e = (exp_gp.size() != 0) ? exp_gp.pop_front() : -1;
        tests_run++;
        if (gauss_pixel_a !== 8'(e)) begin
          tests_failed++;
          $display("FAIL gauss_pixel_3x3: got %0d, expected %0d", gauss_pixel_a, e);
        end
      end
      if (wr_en_a) begin
        e = (exp_wa.size() != 0) ? exp_wa.pop_front() : -1;
        tests_run++;
        if (wr_addr_a !== 16'(e)) begin
          tests_failed++;
          $display("FAIL wr_addr_3x3: got %0d, expected %0d", wr_addr_a, e);
        end
        e = (exp_wd.size() != 0) ? exp_wd.pop_front() : -1;
        tests_run++;
        if (wr_data_a !== 8'(e)) begin
          tests_failed++;
          $display("FAIL wr_data_3x3: got %h, expected %h", wr_data_a, 8'(e));
        end
      end
      if (done_a && done_cyc < 0) done_cyc = cyc;
      @(negedge clk);
    end
    tests_run++;
    if (exp_rd.size() + exp_ga.size() + exp_wa.size() !== 0) begin
      tests_failed++;
      $display("FAIL events_3x3: got %0d unconsumed, expected 0",
               exp_rd.size() + exp_ga.size() + exp_wa.size());
    end
    tests_run++;
    if (done_cyc - first_rd !== 21) begin
      tests_failed++;
      $display("FAIL done_latency_3x3: got %0d, expected 21", done_cyc - first_rd);
    end
    tests_run++;
    if (overlap !== 0) begin
      tests_failed++;
      $display("FAIL strobe_exclusive_3x3: got %0d overlaps, expected 0", overlap);
    end
  endtask

  task automatic test_frame_4x4();
    int exp_rd[$];
    int exp_wa[$];
    int exp_wd[$];
    int lit22 [9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    int e;
    int sum;
    int a;
    int busy_cycles = 0;
    int dones = 0;
    for (int r = 1; r <= 2; r++) begin
      for (int c = 1; c <= 2; c++) begin
        sum = 0;
        for (int k = 0; k < 9; k++) begin
          if (r == 2 && c == 2) a = lit22[k];
          else a = (r - 1 + k / 3) * 4 + (c - 1 + k % 3);
          exp_rd.push_back(a);
          sum += a;
        end
        exp_wa.push_back(256 + (r - 1) * 2 + (c - 1));
        exp_wd.push_back(sum >> 4);
      end
    end
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    for (int cyc = 1; cyc <= 120; cyc++) begin
      if (busy_b) busy_cycles++;
      if (done_b) dones++;
      if (rd_en_b) begin
        e = (exp_rd.size() != 0) ? exp_rd.pop_front() : -1;
        tests_run++;
        if (rd_addr_b !== 16'(e)) begin
          tests_failed++;
          $display("FAIL rd_addr_4x4: got %0d, expected %0d", rd_addr_b, e);
        end
      end
      if (wr_en_b) begin
        e = (exp_wa.size() != 0) ? exp_wa.pop_front() : -1;
        tests_run++;
        if (wr_addr_b !== 16'(e)) begin
          tests_failed++;
          $display("FAIL wr_addr_4x4: got %0d, expected %0d", wr_addr_b, e);
        end
        e = (exp_wd.size() != 0) ? exp_wd.pop_front() : -1;
        tests_run++;
        if (wr_data_b !== 8'(e)) begin
          tests_failed++;
          $display("FAIL wr_data_4x4: got %0d, expected %0d", wr_data_b, e);
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (exp_rd.size() + exp_wa.size() !== 0) begin
      tests_failed++;
      $display("FAIL events_4x4: got %0d unconsumed, expected 0", exp_rd.size() + exp_wa.size());
    end
    tests_run++;
    if (busy_cycles !== 84) begin
      tests_failed++;
      $display("FAIL busy_time_4x4: got %0d, expected 84", busy_cycles);
    end
    tests_run++;
    if (dones !== 1) begin
      tests_failed++;
      $display("FAIL done_count_4x4: got %0d, expected 1", dones);
    end
  endtask

  task automatic test_start_ignored();
    int rds = 0;
    int wrs = 0;
    int dones = 0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (rd_en_a) rds++;
      if (wr_en_a) wrs++;
      if (done_a) dones++;
      start_a = (cyc == 5) || (cyc == 12) || done_a;
      @(negedge clk);
    end
    start_a = 1'b0;
    tests_run++;
    if (rds !== 9) begin
      tests_failed++;
      $display("FAIL ignored_start_reads: got %0d, expected 9", rds);
    end
    tests_run++;
    if (wrs !== 1) begin
      tests_failed++;
      $display("FAIL ignored_start_writes: got %0d, expected 1", wrs);
    end
    tests_run++;
    if (dones !== 1) begin
      tests_failed++;
      $display("FAIL ignored_start_dones: got %0d, expected 1", dones);
    end
  endtask

  task automatic test_filter_lat0();
    int exp_wd[$];
    int e;
    int first_rd = -1;
    int last_we = -1;
    int wr_cyc = -1;
    int done_cyc = -1;
    int busy_cycles = 0;
    exp_wd.push_back(8'hC3);
    @(negedge clk); start_f = 1'b1;
    @(negedge clk); start_f = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (busy_f) busy_cycles++;
      if (rd_en_f && first_rd < 0) first_rd = cyc;
      if (gauss_we_f && gauss_addr_f == 4'd9) last_we = cyc;
      if (wr_en_f) begin
        wr_cyc = cyc;
        e = (exp_wd.size() != 0) ? exp_wd.pop_front() : -1;
        tests_run++;
        if ({wr_addr_f, wr_data_f} !== {16'd256, 8'(e)}) begin
          tests_failed++;
          $display("FAIL wr_lat0: got addr=%0d data=%h, expected addr=256 data=%h",
                   wr_addr_f, wr_data_f, 8'(e));
        end
      end
      if (done_f && done_cyc < 0) done_cyc = cyc;
      @(negedge clk);
    end
    tests_run++;
    if (wr_cyc - last_we !== 1 || last_we < 0) begin
      tests_failed++;
      $display("FAIL store_after_k9_lat0: got gap %0d, expected 1", wr_cyc - last_we);
    end
    tests_run++;
    if (busy_cycles !== 19) begin
      tests_failed++;
      $display("FAIL busy_time_lat0: got %0d, expected 19", busy_cycles);
    end
    tests_run++;
    if (done_cyc - first_rd !== 19) begin
      tests_failed++;
      $display("FAIL done_latency_lat0: got %0d, expected 19", done_cyc - first_rd);
    end
  endtask

  task automatic test_degenerate();
    int done_cyc = -1;
    int activity = 0;
    @(negedge clk); start_w = 1'b1;
    @(negedge clk); start_w = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (done_w && done_cyc < 0) done_cyc = cyc;
      if (rd_en_w || wr_en_w || gauss_we_w || busy_w) activity++;
      @(negedge clk);
    end
    tests_run++;
    if (done_cyc !== 1) begin
      tests_failed++;
      $display("FAIL done_degenerate: got cycle %0d, expected 1", done_cyc);
    end
    tests_run++;
    if (activity !== 0) begin
      tests_failed++;
      $display("FAIL activity_degenerate: got %0d, expected 0", activity);
    end
  endtask

  initial begin
    test_reset();
    test_frame_3x3();
    test_frame_4x4();
    test_start_ignored();
    test_filter_lat0();
    test_degenerate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
